// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer: prioritises timeout, memory wait, branch flush and hazard stall.
// Optional saturating stall statistics are enabled by defining STALL_STATS_EN.
module pipeline_stall_ctrl #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_detected,
  input  logic             branch_taken,
  input  logic             mem_access,
  input  logic             mem_ready,
  output logic             freeze_pc,
  output logic             freeze_if_id,
  output logic             flush_if_id,
  output logic             bubble_id_ex,
  output logic             freeze_all,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] hazard_stall_cnt,
  output logic [CNT_W-1:0] mem_stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {StRun, StMemWait, StTimeout} state_e;

  localparam logic [CNT_W-1:0] CntOne     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(MEM_TIMEOUT);

  state_e           state_q;
  logic [CNT_W-1:0] wait_cnt_q;

  logic mem_wait;
  logic in_timeout;
  logic do_flush;
  logic do_hazard;

  always_comb begin
    in_timeout = (state_q == StTimeout);
    // Once waiting, the freeze holds until mem_ready regardless of mem_access.
    unique case (state_q)
      StRun:     mem_wait = mem_access && !mem_ready;
      StMemWait: mem_wait = !mem_ready;
      default:   mem_wait = 1'b0;
    endcase
    do_flush  = !in_timeout && !mem_wait && branch_taken;
    do_hazard = !in_timeout && !mem_wait && !branch_taken && hazard_detected;
  end

  always_comb begin
    freeze_all   = rst && (in_timeout || mem_wait);
    freeze_pc    = rst && (in_timeout || mem_wait || do_hazard);
    freeze_if_id = rst && (in_timeout || mem_wait || do_hazard);
    flush_if_id  = rst && do_flush;
    bubble_id_ex = rst && (do_flush || do_hazard);
    mem_timeout  = rst && in_timeout;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StRun;
      wait_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (mem_wait) begin
            state_q    <= StMemWait;
            wait_cnt_q <= CntOne;
          end else begin
            wait_cnt_q <= '0;
          end
        end
        StMemWait: begin
          if (mem_ready) begin
            state_q    <= StRun;
            wait_cnt_q <= '0;
          end else if ((MEM_TIMEOUT != 0) && (wait_cnt_q == TimeoutVal)) begin
            state_q <= StTimeout;
          end else if (wait_cnt_q != '1) begin
            wait_cnt_q <= wait_cnt_q + CntOne;
          end
        end
        StTimeout: state_q <= StTimeout;
        default: begin
          state_q    <= StRun;
          wait_cnt_q <= '0;
        end
      endcase
    end
  end

`ifdef STALL_STATS_EN
  logic [CNT_W-1:0] hazard_cnt_q;
  logic [CNT_W-1:0] mem_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      hazard_cnt_q <= '0;
      mem_cnt_q    <= '0;
      flush_cnt_q  <= '0;
    end else begin
      if (do_hazard && (hazard_cnt_q != '1)) hazard_cnt_q <= hazard_cnt_q + CntOne;
      if (mem_wait && (mem_cnt_q != '1))     mem_cnt_q    <= mem_cnt_q + CntOne;
      if (do_flush && (flush_cnt_q != '1))   flush_cnt_q  <= flush_cnt_q + CntOne;
    end
  end

  assign hazard_stall_cnt = rst ? hazard_cnt_q : '0;
  assign mem_stall_cnt    = rst ? mem_cnt_q    : '0;
  assign flush_cnt        = rst ? flush_cnt_q  : '0;
`else
  assign hazard_stall_cnt = '0;
  assign mem_stall_cnt    = '0;
  assign flush_cnt        = '0;
`endif

endmodule
